// File: rtl/io_bus_arbiter_if.sv
// Master-side and dma_io-side signals of the two-master IO bus arbiter.
// The slave modport is the arbiter's view; master is the agent view.
interface io_bus_arbiter_if #(
  parameter int AW = 14
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_adr;
  logic [31:0]   m0_wdata;
  logic          m0_gnt;
  logic [31:0]   m0_rdata;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_adr;
  logic [31:0]   m1_wdata;
  logic          m1_gnt;
  logic [31:0]   m1_rdata;
  logic          m1_rvalid;

  logic          dma_io_we;
  logic [AW-1:0] dma_io_wadr;
  logic [31:0]   dma_io_wdata;
  logic [AW-1:0] dma_io_radr;
  logic [31:0]   dma_io_rdata;

  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_we, m1_adr, m1_wdata,
    output m1_gnt, m1_rdata, m1_rvalid,
    output dma_io_we, dma_io_wadr,
    output dma_io_wdata, dma_io_radr,
    input  dma_io_rdata
  );

  modport master (
    output m0_req, m0_we, m0_adr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_we, m1_adr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  dma_io_we, dma_io_wadr,
    input  dma_io_wdata, dma_io_radr,
    output dma_io_rdata
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin dma_io arbiter (CPU m0, UART monitor m1) with bounded hold.
// Define IO_ARB_FIXED_PRI_EN for fixed priority where m0 always wins.
module io_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int AW       = 14
) (
  input logic             clk,
  input logic             rst_n,
  io_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t        state;
  state_t        state_nxt;
  state_t        tie_win;
  logic [7:0]    hold_cnt;
  logic [7:0]    hold_nxt;
  logic          rd_pend;
  logic          rd_owner;
  logic          acc0;
  logic          acc1;
  logic          acc_we;
  logic          force0;
  logic          force1;
  logic [AW-1:0] adr_mux;

  assign acc0 = (state == GNT0) && bus.m0_req;
  assign acc1 = (state == GNT1) && bus.m1_req;

`ifdef IO_ARB_FIXED_PRI_EN
  assign tie_win = GNT0;
  assign force0  = 1'b0;
  assign force1  = 1'b1;
`else
  logic last;

  assign tie_win = last ? GNT0 : GNT1;
  assign force0  = (hold_cnt == HOLD_MAX);
  assign force1  = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (state != IDLE && state_nxt != state) begin
      last <= (state == GNT1);
    end
  end
`endif

  always_comb begin
    adr_mux          = '0;
    acc_we           = 1'b0;
    bus.dma_io_wdata = '0;
    unique case (1'b1)
      acc0: begin
        adr_mux          = bus.m0_adr;
        acc_we           = bus.m0_we;
        bus.dma_io_wdata = bus.m0_wdata;
      end
      acc1: begin
        adr_mux          = bus.m1_adr;
        acc_we           = bus.m1_we;
        bus.dma_io_wdata = bus.m1_wdata;
      end
      default: ;
    endcase
  end

  assign bus.dma_io_we   = acc_we;
  assign bus.dma_io_wadr = adr_mux;
  assign bus.dma_io_radr = adr_mux;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_nxt = tie_win;
        end else if (bus.m0_req) begin
          state_nxt = GNT0;
        end else if (bus.m1_req) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!bus.m0_req) begin
          state_nxt = bus.m1_req ? GNT1 : IDLE;
        end else if (bus.m1_req && force0) begin
          state_nxt = GNT1;
        end
      end
      GNT1: begin
        if (!bus.m1_req) begin
          state_nxt = bus.m0_req ? GNT0 : IDLE;
        end else if (bus.m0_req && force1) begin
          state_nxt = GNT0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating tenure counter; any grant change starts a new tenure.
  always_comb begin
    hold_nxt = hold_cnt;
    if (state_nxt != state) begin
      hold_nxt = '0;
    end else if ((acc0 || acc1) && hold_cnt != HOLD_MAX) begin
      hold_nxt = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rd_pend  <= (acc0 || acc1) && !acc_we;
      rd_owner <= acc1;
    end
  end

  assign bus.m0_gnt    = (state == GNT0);
  assign bus.m1_gnt    = (state == GNT1);
  // Read data follows the recorded owner, not the current grant.
  assign bus.m0_rvalid = rd_pend && !rd_owner;
  assign bus.m1_rvalid = rd_pend && rd_owner;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.dma_io_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.dma_io_rdata : '0;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized bench for io_bus_arbiter against a tenure-level model.
// Build with IO_ARB_FIXED_PRI_EN to check the fixed-priority variant.
module tb_io_bus_arbiter;
  localparam int AW       = 14;
  localparam int MAX_HOLD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  io_bus_arbiter_if #(.AW(AW)) bus ();

  io_bus_arbiter #(
    .MAX_HOLD(MAX_HOLD),
    .AW      (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  function automatic logic [31:0] slave_f(logic [AW-1:0] a);
    return 32'({a, ~a, 4'hA});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.dma_io_rdata <= '0;
    else bus.dma_io_rdata <= slave_f(bus.dma_io_radr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: owner 0=none,1=m0,2=m1; pref = who wins the next tie.
  int            m_owner;
  int            m_pref;
  int            m_n;
  bit            m_pend;
  int            m_pwho;
  logic [AW-1:0] m_padr;
  bit            e_gnt [2];
  logic          o_g0;
  logic          o_g1;

  task automatic model_reset();
    m_owner  = 0;
    m_pref   = 0;
    m_n      = 0;
    m_pend   = 0;
    m_pwho   = 0;
    m_padr   = '0;
    e_gnt[0] = 0;
    e_gnt[1] = 0;
  endtask

  task automatic set_m(int i, bit rq, bit we,
                       logic [AW-1:0] a, logic [31:0] d);
    if (i == 0) begin
      bus.m0_req = rq; bus.m0_we = we;
      bus.m0_adr = a;  bus.m0_wdata = d;
    end else begin
      bus.m1_req = rq; bus.m1_we = we;
      bus.m1_adr = a;  bus.m1_wdata = d;
    end
  endtask

  task automatic step();
    bit            r [2];
    bit            w [2];
    logic [AW-1:0] a [2];
    logic [31:0]   d [2];
    bit            acc;
    bit            pre;
    int            o;
    int            y;
    int            nxt;
    logic [AW-1:0] e_adr;
    logic [31:0]   e_wd;
    bit            e_we;
    bit            rv0;
    bit            rv1;
    @(negedge clk);
    r[0] = bus.m0_req; w[0] = bus.m0_we;
    a[0] = bus.m0_adr; d[0] = bus.m0_wdata;
    r[1] = bus.m1_req; w[1] = bus.m1_we;
    a[1] = bus.m1_adr; d[1] = bus.m1_wdata;
    o = m_owner - 1;
    acc = 0;
    if (m_owner != 0) acc = r[o];
    e_we = 0; e_adr = '0; e_wd = '0;
    if (acc) begin
      e_we = w[o]; e_adr = a[o]; e_wd = d[o];
    end
    rv0 = m_pend && m_pwho == 0;
    rv1 = m_pend && m_pwho == 1;
    o_g0 = bus.m0_gnt;
    o_g1 = bus.m1_gnt;
    check("m0_gnt", 32'(bus.m0_gnt), 32'(m_owner == 1));
    check("m1_gnt", 32'(bus.m1_gnt), 32'(m_owner == 2));
    check("we", 32'(bus.dma_io_we), 32'(e_we));
    check("wadr", 32'(bus.dma_io_wadr), 32'(e_adr));
    check("radr", 32'(bus.dma_io_radr), 32'(e_adr));
    check("wdata", bus.dma_io_wdata, e_wd);
    check("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv0));
    check("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv1));
    check("m0_rdata", bus.m0_rdata, rv0 ? slave_f(m_padr) : 32'h0);
    check("m1_rdata", bus.m1_rdata, rv1 ? slave_f(m_padr) : 32'h0);
    e_gnt[0] = (m_owner == 1);
    e_gnt[1] = (m_owner == 2);
    nxt = m_owner;
    y = 0;
    if (m_owner == 0) begin
      if (r[0] && r[1]) nxt = m_pref + 1;
      else if (r[0]) nxt = 1;
      else if (r[1]) nxt = 2;
    end else begin
      y = 1 - o;
`ifdef IO_ARB_FIXED_PRI_EN
      pre = (o == 1);
`else
      pre = (m_n + 1 >= MAX_HOLD);
`endif
      if (!r[o]) nxt = r[y] ? y + 1 : 0;
      else if (r[y] && pre) nxt = y + 1;
    end
    m_pend = acc && !w[o >= 0 ? o : 0];
    if (acc) begin
      m_pwho = o;
      m_padr = a[o];
    end
    if (nxt != m_owner) begin
`ifndef IO_ARB_FIXED_PRI_EN
      if (m_owner != 0) m_pref = y;
`endif
      m_n = 0;
    end else if (acc) begin
      m_n++;
    end
    m_owner = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_g0"}, 32'(bus.m0_gnt), 0);
    check({tag, "_g1"}, 32'(bus.m1_gnt), 0);
    check({tag, "_rv0"}, 32'(bus.m0_rvalid), 0);
    check({tag, "_rv1"}, 32'(bus.m1_rvalid), 0);
    check({tag, "_rd0"}, bus.m0_rdata, 0);
    check({tag, "_rd1"}, bus.m1_rdata, 0);
    check({tag, "_we"}, 32'(bus.dma_io_we), 0);
    check({tag, "_wadr"}, 32'(bus.dma_io_wadr), 0);
    check({tag, "_radr"}, 32'(bus.dma_io_radr), 0);
    check({tag, "_wdata"}, bus.dma_io_wdata, 0);
  endtask

  int n0;
  int first1;
  bit gap;

  initial begin
    model_reset();
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    #2;
    check_all_zero("rst");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // m1 write from reset: granted in cycle 1
    set_m(1, 1, 1, 14'h3000, 32'h5);
    step();
    step();
    set_m(1, 0, 0, '0, '0);
    step();
    step();

    // m0 read, data returns one cycle after the access
    set_m(0, 1, 0, 14'h3001, 32'h0);
    step();
    step();
    set_m(0, 0, 0, '0, '0);
    step();
    step();

    // bounded hold, then m1 reads across the handover
    set_m(0, 1, 1, 14'h0100, 32'hCAFE_0001);
    step();
    set_m(1, 1, 0, 14'h0222, 32'h0);
    n0 = 0;
    first1 = -1;
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (first1 < 0) begin
        if (o_g1) first1 = k;
        else if (o_g0) n0++;
        else gap = 1;
      end
    end
`ifdef IO_ARB_FIXED_PRI_EN
    check("hold_m0_cycles", 32'(n0), 32'd20);
    check("hold_no_m1", 32'(first1), 32'hFFFF_FFFF);
`else
    check("hold_m0_cycles", 32'(n0), 32'(MAX_HOLD));
    check("hold_first_m1", 32'(first1), 32'(MAX_HOLD));
`endif
    check("hold_no_gap", 32'(gap), 0);
    set_m(0, 0, 0, '0, '0);
    step();
    step();
    set_m(0, 1, 1, 14'h0101, 32'hCAFE_0002);
    for (int k = 0; k < 4; k++) step();
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    step();
    step();

    // reset while m1 owns the bus with a read pending
    set_m(1, 1, 0, 14'h0333, 32'h0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    model_reset();
    set_m(1, 0, 0, '0, '0);
    #1 rst_n = 1'b1;
    step();
    set_m(0, 1, 1, 14'h0011, 32'h11);
    set_m(1, 1, 1, 14'h0022, 32'h22);
    step();
    step();
    check("tie_after_rst", 32'(o_g0), 1);
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    step();
    step();

    // round-robin tie: m0 left last, so m1 wins
    set_m(0, 1, 1, 14'h0044, 32'h44);
    set_m(1, 1, 1, 14'h0055, 32'h55);
    step();
    step();
`ifdef IO_ARB_FIXED_PRI_EN
    check("tie_rr", 32'(o_g0), 1);
`else
    check("tie_rr", 32'(o_g1), 1);
`endif
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    step();
    step();

    // random traffic under the master protocol
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        bit rq;
        rq = (i == 0) ? bus.m0_req : bus.m1_req;
        if ((rq && e_gnt[i]) || (!rq && $urandom_range(1, 0) == 1))
          set_m(i, $urandom_range(3, 0) != 0,
                1'($urandom), AW'($urandom),
                $urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single dma_io peripheral bus (LED and other IO slaves) between two masters.
- m0 is the CPU core load/store IO path; m1 is the UART debug monitor.
- Round-robin grant FSM with bounded hold.
- Muxes address, write data and write enable onto the bus; routes the one-cycle-latency read data back to the master that issued the read.

Parameters:
MAX_HOLD, 8, max consecutive granted cycles for one master while the other is requesting (legal range 1..255)
AW, 14, IO word-address width (bits [15:2])

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  CPU requests bus; held until access done
m0_we  in  1  1 = write, 0 = read
m0_adr  in  AW  word address [15:2]
m0_wdata  in  32  write data
m0_gnt  out  1  m0 owns bus this cycle
m0_rdata  out  32  read data
m0_rvalid  out  1  m0_rdata valid this cycle
m1_req, m1_we, m1_adr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same as m0, for UART monitor
dma_io_we  out  1  bus write strobe
dma_io_wadr  out  AW  bus write address
dma_io_wdata  out  32  bus write data
dma_io_radr  out  AW  bus read address
dma_io_rdata  in  32  slave read data, valid 1 cycle after radr presented

Behaviour:
- Single clock domain: clk. Reset: rst_n, asynchronous, active-low.
- Reset values:
  - state=IDLE, last=1 (so m0 wins first tie), hold_cnt=0, rd_pend=0, rd_owner=0.
  - All outputs 0; any read pending at reset is dropped.
- States: IDLE, GNT0, GNT1. gnt outputs decode directly from the registered state (m0_gnt = state==GNT0).
- IDLE:
  - only m0_req -> GNT0; only m1_req -> GNT1.
  - both requesting -> grant the master != last.
  - neither -> stay IDLE.
- GNTx, access cycle = gntx && mx_req:
  - dma_io_we = mx_we; dma_io_wadr = dma_io_radr = mx_adr; dma_io_wdata = mx_wdata.
  - Outside an access cycle: dma_io_we=0 and address/data buses driven 0.
- GNTx hold counter:
  - hold_cnt increments on each access cycle; saturates at MAX_HOLD-1.
  - Cleared on every state change.
- GNTx exits:
  - mx_req=0: -> GNTy if my_req, else IDLE.
  - mx_req=1, my_req=1, hold_cnt==MAX_HOLD-1: -> GNTy after this access completes (forced handover).
  - Otherwise stay in GNTx.
  - On leaving GNTx, last <= x.
- Handover adds no bubble (the next cycle is GNTy). The cycle in which mx_req is already low is a bus-idle cycle.
- Read return:
  - An access cycle with we=0 sets rd_pend=1, rd_owner=x.
  - Next cycle: mx_rvalid=1 and mx_rdata=dma_io_rdata. The other master's rdata=0 and rvalid=0.
  - Back-to-back reads pipeline: rd_pend and rd_owner reload every cycle.
  - A read issued on the last cycle before handover still returns to its owner, even though the grant has already moved.
- Writes complete in the access cycle; there is no ack beyond gnt.
- Master protocol: a master holds adr/we/wdata stable while req=1 && gnt=0. Each gnt&&req cycle consumes one access.
- Simultaneous IDLE request with last=1 grants m0; with last=0 grants m1.

Optional Feature:
- Macro: IO_ARB_FIXED_PRI_EN.
- Defined:
  - Fixed priority, m0 always wins; last is unused.
  - In GNT1, an m0_req forces handover after the current m1 access, ignoring MAX_HOLD.
  - m1 never preempts m0.
- Undefined: round-robin with MAX_HOLD as specified above.

Test Plan:
- Reset, then m1_req=1 write adr=0x3000, wdata=0x5 -> m1_gnt at cycle 1, dma_io_we=1 with wadr=0x3000 and wdata=0x5 in the same cycle; m0 outputs stay 0.
- m0 read adr=0x3001 while slave returns 0xA5A5_0001 one cycle later -> m0_rvalid=1, m0_rdata=0xA5A5_0001 exactly one cycle after the access; m1_rvalid=0.
- Both req from IDLE after reset -> GNT0 first. Drop both, re-request both -> GNT1 (round-robin).
- m0 holds req continuously, m1 requests, MAX_HOLD=8 -> exactly 8 m0 access cycles, then m1_gnt next cycle with no idle cycle between.
- m1 read on its last granted cycle with a handover to m0 -> m1_rvalid asserted in the first GNT0 cycle with correct data; m0_rvalid=0.
- Assert rst_n low during GNT1 with a read pending -> all outputs 0 immediately, no rvalid after release, and the first tie after release goes to m0. IO_ARB_FIXED_PRI_EN build: in GNT1, m0_req -> GNT0 after one m1 access.
